// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param: WIDTH x WIDTH sequential multiplier using radix-2 Booth
// recoding, one step per clock. Operands are widened to WIDTH+1 bits so the same
// signed Booth datapath serves both unsigned and two's-complement modes.
module seq_multiplier_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   v1,
  input  logic [WIDTH-1:0]   v2,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int XW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [XW-1:0] mcand;
  logic [XW-1:0] acc;
  logic [XW-1:0] mplier;
  logic          q_m1;
  logic [CW-1:0] count;

  logic [XW-1:0] ext_v1;
  logic [XW-1:0] ext_v2;
  logic [XW-1:0] acc_sum;

  // Widen operands by one bit: sign bit copied in signed mode, zero otherwise
  always_comb begin
    ext_v1 = {signed_mode & v1[WIDTH-1], v1};
    ext_v2 = {signed_mode & v2[WIDTH-1], v2};
  end

  // Booth add/subtract selected by the multiplier LSB and the previous bit
  always_comb begin
    case ({mplier[0], q_m1})
      2'b01:   acc_sum = acc + mcand;
      2'b10:   acc_sum = acc - mcand;
      default: acc_sum = acc;
    endcase
  end

  // Controller and datapath: accept, iterate WIDTH+1 Booth steps, publish result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      out    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      q_m1   <= 1'b0;
      count  <= '0;
    end else begin
      done <= 1'b0;

      case (state)
        CALC: begin
          // Arithmetic shift of {acc_sum, mplier, q_m1} right by one
          acc    <= {acc_sum[XW-1], acc_sum[XW-1:1]};
          mplier <= {acc_sum[0], mplier[XW-1:1]};
          q_m1   <= mplier[0];
          count  <= count + 1'b1;
          if (count == CW'(WIDTH)) begin
            state <= DONE;
            ready <= 1'b1;
          end
        end
        DONE: begin
          // Low 2*WIDTH bits of the (2*WIDTH+2)-bit product are exact in both modes
          out   <= {acc[WIDTH-2:0], mplier};
          done  <= 1'b1;
          state <= IDLE;
        end
        IDLE: begin
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase

      // A start seen while ready (IDLE or DONE) begins a new run; this overrides
      // the DONE->IDLE transition so back-to-back products need no idle cycle.
      if (ready && start) begin
        mcand  <= ext_v1;
        mplier <= ext_v2;
        acc    <= '0;
        q_m1   <= 1'b0;
        count  <= '0;
        state  <= CALC;
        ready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Testbench for seq_multiplier_param: directed cases with literal expectations,
// then randomized traffic compared every cycle against a countdown/arithmetic model.
module tb_seq_multiplier_param;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  v1 = '0;
  logic [7:0]  v2 = '0;
  logic        ready;
  logic        done;
  logic [15:0] out;

  logic        s_start = 1'b0;
  logic        s_mode = 1'b0;
  logic [15:0] s_v1 = '0;
  logic [15:0] s_v2 = '0;
  logic        s_ready;
  logic        s_done;
  logic [31:0] s_out;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model state: cycles until the pending product appears
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_out = '0;
  logic [15:0] m_pend = '0;

  seq_multiplier_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .v1(v1), .v2(v2), .ready(ready), .done(done), .out(out)
  );

  seq_multiplier_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(s_start), .signed_mode(s_mode),
    .v1(s_v1), .v2(s_v2), .ready(s_ready), .done(s_done), .out(s_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
    longint sa;
    longint sb;
    longint p;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    return p[15:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: accept when ready, product appears W+2 edges later
  always @(posedge clk or negedge rst) begin
    int c;
    logic rdy;
    if (!rst) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_out  = '0;
    end else begin
      c      = m_cnt;
      rdy    = (c <= 1);
      m_done = 1'b0;
      if (c > 0) begin
        c--;
        if (c == 0) begin
          m_done = 1'b1;
          m_out  = m_pend;
        end
      end
      if (rdy && start) begin
        c      = W + 2;
        m_pend = ref_prod(v1, v2, signed_mode);
      end
      m_cnt = c;
    end
  end

  // Every-cycle comparison of the 8-bit instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready", 64'(ready), 64'(m_cnt <= 1));
      chk("cyc_done",  64'(done),  64'(m_done));
      chk("cyc_out",   64'(out),   64'(m_out));
    end
  end

  task automatic do_start8(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    v1 = a; v2 = b; signed_mode = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done8(input int maxc, output int n, output int rlow);
    bit got;
    got = 1'b0; n = 0; rlow = 0;
    while (!got && n < maxc) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else if (!ready) rlow++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout8: got no done expected done within %0d cycles", maxc);
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [31:0] exp, input string nm);
    int n;
    bit got;
    @(negedge clk);
    s_v1 = a; s_v2 = b; s_mode = s; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (s_done) got = 1'b1;
    end
    chk({nm, "_seen"}, 64'(got), 64'd1);
    chk({nm, "_lat"}, 64'(n), 64'd18);
    chk(nm, 64'(s_out), 64'(exp));
  endtask

  initial begin
    int n;
    int rl;
    int r0;
    int extra;
    logic [7:0] pick [5];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_out",   64'(out),   64'd0);
    chk("rst_ready16", 64'(s_ready), 64'd1);
    rst = 1'b1;
    chk_en = 1'b1;

    // Pin the model's arithmetic with hand-computed products
    chk("model_ffff_u", 64'(ref_prod(8'hFF, 8'hFF, 1'b0)), 64'hFE01);
    chk("model_8080_s", 64'(ref_prod(8'h80, 8'h80, 1'b1)), 64'h4000);
    chk("model_ff01_s", 64'(ref_prod(8'hFF, 8'h01, 1'b1)), 64'hFFFF);

    // Unsigned all-ones, latency and ready-low window
    do_start8(8'hFF, 8'hFF, 1'b0);
    r0 = ready ? 0 : 1;
    wait_done8(30, n, rl);
    chk("lat_ffxff", 64'(n), 64'd10);
    chk("ready_low_ffxff", 64'(rl + r0), 64'd9);
    chk("out_ffxff_u", 64'(out), 64'hFE01);

    do_start8(8'h80, 8'h80, 1'b1);
    wait_done8(30, n, rl);
    chk("out_80x80_s", 64'(out), 64'h4000);
    do_start8(8'hFF, 8'h01, 1'b1);
    wait_done8(30, n, rl);
    chk("out_ffx01_s", 64'(out), 64'hFFFF);
    do_start8(8'hFF, 8'h01, 1'b0);
    wait_done8(30, n, rl);
    chk("out_ffx01_u", 64'(out), 64'h00FF);

    // Start re-pulsed during CALC must be ignored
    do_start8(8'h0C, 8'h0A, 1'b0);
    repeat (3) @(negedge clk);
    v1 = 8'h03; v2 = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done8(30, n, rl);
    chk("out_0cx0a_ignore", 64'(out), 64'h0078);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("no_extra_done", 64'(extra), 64'd0);

    // Back-to-back with start held through done
    @(negedge clk);
    v1 = 8'h10; v2 = 8'h10; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    v1 = 8'h07; v2 = 8'h09;
    wait_done8(30, n, rl);
    chk("b2b_lat1", 64'(n), 64'd10);
    chk("out_b2b_10x10", 64'(out), 64'h0100);
    start = 1'b0;
    wait_done8(30, n, rl);
    chk("b2b_gap", 64'(n), 64'd10);
    chk("out_b2b_07x09", 64'(out), 64'h003F);

    // Asynchronous reset mid-run
    do_start8(8'h33, 8'h44, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_done",  64'(done),  64'd0);
    chk("midrst_out",   64'(out),   64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    do_start8(8'h05, 8'h06, 1'b0);
    wait_done8(30, n, rl);
    chk("out_05x06_after_rst", 64'(out), 64'h001E);

    // Wider instance
    run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_ffff_u");
    run16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "w16_8000x7fff_s");

    // Randomized traffic: start pulses, busy-time noise, occasional reset
    pick[0] = 8'h00; pick[1] = 8'h80; pick[2] = 8'hFF; pick[3] = 8'h7F; pick[4] = 8'h01;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start       = ($urandom_range(0, 2) == 0);
      signed_mode = 1'($urandom_range(0, 1));
      v1 = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 8'($urandom);
      v2 = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
      end
    end
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_param.md
Name: seq_multiplier_param

Overview:
Parametrised sequential multiplier, successor to the fixed 8x8 shift-add multiplier. Computes a WIDTH x WIDTH product with a start/ready/done handshake. A run-time mode input selects unsigned or two's-complement signed operation. Internally uses radix-2 Booth recoding, one iteration per clock. Controller and datapath live in a single module.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous, active-low
start  input  1  request; sampled only while ready=1
signed_mode  input  1  0 = unsigned operands, 1 = two's-complement signed; latched with operands
v1  input  WIDTH  multiplicand; latched on accepted start
v2  input  WIDTH  multiplier; latched on accepted start
ready  output  1  1 = idle, will accept start
done  output  1  single-cycle pulse; out holds a new product
out  output  2*WIDTH  product; holds the last result until the next completion

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ready=1, done=0, out=0, all internal registers cleared. Reset mid-operation aborts the run; no done pulse is produced.
- States: IDLE, CALC, DONE.
- IDLE: ready=1. At an edge with start=1:
  - latch v1, v2 and signed_mode;
  - extend both operands to WIDTH+1 bits (sign-extend if signed_mode=1, zero-extend otherwise);
  - clear the accumulator and Booth bit q(-1), set counter=0, go to CALC.
- CALC: ready=0. Each edge performs one Booth step on the pair {q0, q(-1)}:
  - 01: add multiplicand to the accumulator upper half;
  - 10: subtract multiplicand;
  - 00/11: no add;
  - then arithmetic-shift {acc, mplier, q(-1)} right by 1 and increment the counter.
  - After WIDTH+1 steps, go to DONE.
  - Counter width is clog2(WIDTH+2).
- DONE (one cycle): out <= low 2*WIDTH bits of the (2*WIDTH+2)-bit product. This is exact in both modes. done=1 and ready=1 in the same cycle; next state is IDLE.
- start asserted during the DONE cycle is accepted (back-to-back). The next product's done arrives WIDTH+2 cycles later.
- Latency: start accepted at edge k -> done=1 and out valid in the cycle after edge k+WIDTH+2 (10 cycles for WIDTH=8).
- Throughput: one product per WIDTH+2 cycles.
- start while ready=0 is ignored. Changes on v1, v2 or signed_mode during CALC have no effect.
- out changes only on a DONE transition or on reset. done is low in every other cycle.
- Products involving zero or extreme values need no special casing: 0, the most negative signed operand, and all-ones unsigned are all handled by the WIDTH+1 extension.

Test Plan:
- WIDTH=8, unsigned, v1=0xFF, v2=0xFF -> out=0xFE01, done pulse exactly 10 cycles after start accepted, ready low for 9 cycles in between.
- WIDTH=8, signed, v1=0x80, v2=0x80 (-128*-128) -> out=0x4000. Signed v1=0xFF, v2=0x01 -> out=0xFFFF. Unsigned same operands -> out=0x00FF.
- WIDTH=8, start re-pulsed mid-CALC with v1=0x03, v2=0x03 -> ignored; first run 0x0C*0x0A completes with out=0x0078, no extra done.
- Back-to-back: start held high through done with unsigned 0x10*0x10 then 0x07*0x09 -> out=0x0100 then 0x003F; done pulses 10 cycles apart.
- Reset (rst=0) asserted 4 cycles into a run -> immediately ready=1, done=0, out=0. After release, a new 0x05*0x06 unsigned run -> out=0x001E.
- WIDTH=16, unsigned 0xFFFF*0xFFFF -> out=0xFFFE0001 after 18 cycles. Signed 0x8000*0x7FFF -> out=0xC0008000.
